// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame packer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LATCH,
    SEND,
    WAIT
  } state_t;

  // What the byte currently in flight is: frame header, payload byte or trailer.
  typedef enum logic [1:0] {
    HDR,
    DATA,
    CSUM
  } kind_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'h49;

  // Total bytes on the wire for one frame.
  function automatic int unsigned frame_len(input int unsigned word_width,
                                            input int unsigned words_per_frame,
                                            input bit          checksum_en);
    return 1 + words_per_frame * (word_width / 8) + (checksum_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// Holds one FIFO word and walks through its bytes in the chosen order.
module word_byte_shifter #(
  parameter int WORD_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [7:0]            byte_out,
  output logic                  last_byte
);

  localparam int BYTES = WORD_WIDTH / 8;

  logic [WORD_WIDTH-1:0] sh;
  logic [3:0]            left;

  // Load a fresh word, or move the next byte into the output lane; left counts bytes still to come.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      left <= '0;
    end else if (load) begin
      sh   <= word_in;
      left <= 4'(BYTES - 1);
    end else if (shift && (left != 4'd0)) begin
      sh   <= MSB_FIRST ? (sh << 8) : (sh >> 8);
      left <= left - 4'd1;
    end
  end

  assign byte_out  = MSB_FIRST ? sh[WORD_WIDTH-1 -: 8] : sh[7:0];
  assign last_byte = (left == 4'd0);

endmodule

// File: rtl/uart_frame_packer.sv
// Pops words from the filter FIFO and sends them as framed bytes to the UART.
//
// state | meaning
// IDLE  | no frame in progress; waits for enable and a queued word
// RD    | needs the next word; pops it once the FIFO is non-empty
// LATCH | popped word is on the FIFO data bus; captured into the shifter
// SEND  | byte is selected; waits for the transmitter to be free, then strobes
// WAIT  | byte is on the wire; waits for tx_done and picks what comes next
module uart_frame_packer
  import uart_frame_pkg::*;
#(
  parameter int          WORD_WIDTH      = 32,
  parameter int          WORDS_PER_FRAME = 1,
  parameter logic [7:0]  HEADER_BYTE     = DEFAULT_HEADER,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter bit          CHECKSUM_EN     = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [WORD_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done,
  output logic [7:0]            o_tx_byte,
  output logic                  o_tx_send,
  output logic                  o_busy,
  output logic [15:0]           o_frame_cnt
);

  state_t      state, state_n;
  kind_t       kind, kind_n;
  logic [7:0]  words_left, words_left_n;
  logic [7:0]  csum, csum_n;
  logic [7:0]  tx_byte_n;
  logic        tx_send_n;
  logic        rd_en_n;
  logic [15:0] frame_cnt_n;
  logic        sh_load, sh_shift;
  logic [7:0]  sh_byte;
  logic        sh_last;
  logic [7:0]  csum_byte;

  assign csum_byte = ~csum + 8'd1;

  word_byte_shifter #(
    .WORD_WIDTH(WORD_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (sh_load),
    .shift    (sh_shift),
    .word_in  (i_fifo_data),
    .byte_out (sh_byte),
    .last_byte(sh_last)
  );

  // Register state and all outputs; busy follows the state being entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      kind         <= HDR;
      words_left   <= '0;
      csum         <= '0;
      o_tx_byte    <= '0;
      o_tx_send    <= 1'b0;
      o_fifo_rd_en <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      state        <= state_n;
      kind         <= kind_n;
      words_left   <= words_left_n;
      csum         <= csum_n;
      o_tx_byte    <= tx_byte_n;
      o_tx_send    <= tx_send_n;
      o_fifo_rd_en <= rd_en_n;
      o_busy       <= (state_n != IDLE);
      o_frame_cnt  <= frame_cnt_n;
    end
  end

  // Next-state and next-output decode. The pop strobe is issued as RD is
  // entered when a word is already waiting, so the data lands in LATCH.
  always_comb begin
    state_n      = state;
    kind_n       = kind;
    words_left_n = words_left;
    csum_n       = csum;
    tx_byte_n    = o_tx_byte;
    tx_send_n    = 1'b0;
    rd_en_n      = 1'b0;
    frame_cnt_n  = o_frame_cnt;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable && !i_fifo_empty) begin
          kind_n       = HDR;
          words_left_n = 8'(WORDS_PER_FRAME - 1);
          csum_n       = '0;
          tx_byte_n    = HEADER_BYTE;
          state_n      = SEND;
        end
      end
      SEND: begin
        if (!i_tx_active) begin
          tx_send_n = 1'b1;
          state_n   = WAIT;
          case (kind)
            HDR:     tx_byte_n = HEADER_BYTE;
            DATA: begin
              tx_byte_n = sh_byte;
              csum_n    = csum + sh_byte;
            end
            default: tx_byte_n = csum_byte;
          endcase
        end
      end
      WAIT: begin
        if (i_tx_done) begin
          case (kind)
            HDR: begin
              kind_n  = DATA;
              state_n = RD;
              rd_en_n = !i_fifo_empty;
            end
            DATA: begin
              if (!sh_last) begin
                sh_shift = 1'b1;
                state_n  = SEND;
              end else if (words_left != 8'd0) begin
                words_left_n = words_left - 8'd1;
                state_n      = RD;
                rd_en_n      = !i_fifo_empty;
              end else if (CHECKSUM_EN) begin
                kind_n  = CSUM;
                state_n = SEND;
              end else begin
                frame_cnt_n = o_frame_cnt + 16'd1;
                state_n     = IDLE;
              end
            end
            default: begin
              frame_cnt_n = o_frame_cnt + 16'd1;
              state_n     = IDLE;
            end
          endcase
        end
      end
      RD: begin
        if (o_fifo_rd_en) begin
          state_n = LATCH;
        end else if (!i_fifo_empty) begin
          rd_en_n = 1'b1;
        end
      end
      LATCH: begin
        sh_load = 1'b1;
        state_n = SEND;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench: four packer configurations share one FIFO and UART model,
// with sel choosing which instance is connected to them.
module tb_uart_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  int          sel;
  logic [63:0] fifo_data = '0;
  logic        fifo_empty;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  int          timer = 0;

  logic [63:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [7:0]  log_b [0:255];
  int          nlog = 0;
  int          nrd = 0;
  int          viol = 0;
  int          rd_bad = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  logic        en_a, en_b, en_c, en_d;
  logic        emp_a, emp_b, emp_c, emp_d;
  logic        rd_a, rd_b, rd_c, rd_d;
  logic        snd_a, snd_b, snd_c, snd_d;
  logic        bsy_a, bsy_b, bsy_c, bsy_d;
  logic [7:0]  byt_a, byt_b, byt_c, byt_d;
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;

  assign en_a  = enable && (sel == 0);
  assign en_b  = enable && (sel == 1);
  assign en_c  = enable && (sel == 2);
  assign en_d  = enable && (sel == 3);
  assign emp_a = (sel == 0) ? fifo_empty : 1'b1;
  assign emp_b = (sel == 1) ? fifo_empty : 1'b1;
  assign emp_c = (sel == 2) ? fifo_empty : 1'b1;
  assign emp_d = (sel == 3) ? fifo_empty : 1'b1;

  uart_frame_packer #(.WORD_WIDTH(32), .WORDS_PER_FRAME(1), .MSB_FIRST(1'b1), .CHECKSUM_EN(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en_a), .i_fifo_empty(emp_a), .i_fifo_data(fifo_data[31:0]),
    .o_fifo_rd_en(rd_a), .i_tx_active(tx_active), .i_tx_done(tx_done), .o_tx_byte(byt_a),
    .o_tx_send(snd_a), .o_busy(bsy_a), .o_frame_cnt(cnt_a));

  uart_frame_packer #(.WORD_WIDTH(32), .WORDS_PER_FRAME(1), .MSB_FIRST(1'b0), .CHECKSUM_EN(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en_b), .i_fifo_empty(emp_b), .i_fifo_data(fifo_data[31:0]),
    .o_fifo_rd_en(rd_b), .i_tx_active(tx_active), .i_tx_done(tx_done), .o_tx_byte(byt_b),
    .o_tx_send(snd_b), .o_busy(bsy_b), .o_frame_cnt(cnt_b));

  uart_frame_packer #(.WORD_WIDTH(32), .WORDS_PER_FRAME(2), .MSB_FIRST(1'b1), .CHECKSUM_EN(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_enable(en_c), .i_fifo_empty(emp_c), .i_fifo_data(fifo_data[31:0]),
    .o_fifo_rd_en(rd_c), .i_tx_active(tx_active), .i_tx_done(tx_done), .o_tx_byte(byt_c),
    .o_tx_send(snd_c), .o_busy(bsy_c), .o_frame_cnt(cnt_c));

  uart_frame_packer #(.WORD_WIDTH(16), .WORDS_PER_FRAME(1), .MSB_FIRST(1'b1), .CHECKSUM_EN(1'b0)) dut_d (
    .i_clk(clk), .i_rst(rst), .i_enable(en_d), .i_fifo_empty(emp_d), .i_fifo_data(fifo_data[15:0]),
    .o_fifo_rd_en(rd_d), .i_tx_active(tx_active), .i_tx_done(tx_done), .o_tx_byte(byt_d),
    .o_tx_send(snd_d), .o_busy(bsy_d), .o_frame_cnt(cnt_d));

  logic        send_m, rd_m, busy_m;
  logic [7:0]  byte_m;
  logic [15:0] cnt_m;

  always_comb begin
    send_m = snd_a; rd_m = rd_a; busy_m = bsy_a; byte_m = byt_a; cnt_m = cnt_a;
    case (sel)
      1: begin send_m = snd_b; rd_m = rd_b; busy_m = bsy_b; byte_m = byt_b; cnt_m = cnt_b; end
      2: begin send_m = snd_c; rd_m = rd_c; busy_m = bsy_c; byte_m = byt_c; cnt_m = cnt_c; end
      3: begin send_m = snd_d; rd_m = rd_d; busy_m = bsy_d; byte_m = byt_d; cnt_m = cnt_d; end
      default: ;
    endcase
  end

  // UART transmitter (4 busy cycles then a done pulse) and FIFO read port model.
  always @(posedge clk) begin
    if (rst) begin
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      timer     <= 0;
    end else begin
      tx_done <= 1'b0;
      if (send_m) begin
        if (tx_active) viol <= viol + 1;
        log_b[nlog % 256] <= byte_m;
        nlog      <= nlog + 1;
        tx_active <= 1'b1;
        timer     <= 3;
      end else if (tx_active) begin
        if (timer == 0) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
        end else begin
          timer <= timer - 1;
        end
      end
      if (rd_m) begin
        if (fifo_empty) rd_bad <= rd_bad + 1;
        fifo_data <= mem[rd_ptr % 16];
        rd_ptr    <= rd_ptr + 1;
        nrd       <= nrd + 1;
      end
    end
  end

  task automatic push(input logic [63:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cnt_m == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_nlog(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (nlog == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({send_m, rd_m, busy_m, byte_m} !== 11'd0) begin
      bad++; $display("FAIL reset_outs got=%h want=0", {send_m, rd_m, busy_m, byte_m});
    end
    total++;
    if (cnt_m !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt_m); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_msb_first();
    logic [7:0] e [5] = '{8'h49, 8'h12, 8'h34, 8'h56, 8'h78};
    int b0, r0; bit ok, seen;
    sel = 0;
    @(negedge clk);
    b0 = nlog; r0 = nrd;
    push(64'h12345678);
    enable = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy_m !== 1'b1 || send_m !== 1'b0) begin
      bad++; $display("FAIL t1_cycle1 busy=%b send=%b want busy=1 send=0", busy_m, send_m);
    end
    @(posedge clk); #1;
    total++;
    if (send_m !== 1'b1 || byte_m !== 8'h49) begin
      bad++; $display("FAIL t1_first_send send=%b byte=%h want send=1 byte=49", send_m, byte_m);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (tx_done) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    total++;
    if (!seen || rd_m !== 1'b1) begin
      bad++; $display("FAIL t1_rd_latency done_seen=%b rd_en=%b want 1 1", seen, rd_m);
    end
    wait_cnt(16'd1, 300, ok);
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL t1_frame_done cnt=%0d want 1", cnt_m); end
    total++;
    if (nlog - b0 !== 5) begin bad++; $display("FAIL t1_len got=%0d want 5", nlog - b0); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (log_b[(b0 + i) % 256] !== e[i]) begin
        bad++; $display("FAIL t1_byte%0d got=%h want=%h", i, log_b[(b0 + i) % 256], e[i]);
      end
    end
    total++;
    if (nrd - r0 !== 1) begin bad++; $display("FAIL t1_pops got=%0d want 1", nrd - r0); end
  endtask

  task automatic test_lsb_checksum();
    logic [7:0] e [6] = '{8'h49, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
    int b0; bit ok;
    sel = 1;
    @(negedge clk);
    b0 = nlog;
    push(64'h12345678);
    enable = 1'b1;
    wait_cnt(16'd1, 300, ok);
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL t2_frame_done cnt=%0d want 1", cnt_m); end
    total++;
    if (nlog - b0 !== 6) begin bad++; $display("FAIL t2_len got=%0d want 6", nlog - b0); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (log_b[(b0 + i) % 256] !== e[i]) begin
        bad++; $display("FAIL t2_byte%0d got=%h want=%h", i, log_b[(b0 + i) % 256], e[i]);
      end
    end
  endtask

  task automatic test_fifo_stall();
    logic [7:0] e [9] = '{8'h49, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int b0, r0; bit ok;
    sel = 2;
    @(negedge clk);
    b0 = nlog; r0 = nrd;
    push(64'h11223344);
    enable = 1'b1;
    wait_nlog(b0 + 5, 300, ok);
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL t3_first_word sent=%0d want 5", nlog - b0); end
    repeat (500) @(posedge clk);
    #1;
    total++;
    if (busy_m !== 1'b1 || cnt_m !== 16'd0) begin
      bad++; $display("FAIL t3_stall busy=%b cnt=%0d want busy=1 cnt=0", busy_m, cnt_m);
    end
    total++;
    if (nlog - b0 !== 5 || nrd - r0 !== 1) begin
      bad++; $display("FAIL t3_stall_io sent=%0d pops=%0d want 5 1", nlog - b0, nrd - r0);
    end
    @(negedge clk);
    push(64'hAABBCCDD);
    wait_cnt(16'd1, 300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t3_frame_done cnt=%0d want 1", cnt_m); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (log_b[(b0 + i) % 256] !== e[i]) begin
        bad++; $display("FAIL t3_byte%0d got=%h want=%h", i, log_b[(b0 + i) % 256], e[i]);
      end
    end
    total++;
    if (nrd - r0 !== 2) begin bad++; $display("FAIL t3_pops got=%0d want 2", nrd - r0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [6] = '{8'h49, 8'h00, 8'h01, 8'h49, 8'hFF, 8'hFF};
    int b0, r0, v0; bit ok;
    sel = 3;
    @(negedge clk);
    b0 = nlog; r0 = nrd; v0 = viol;
    push(64'h0001);
    push(64'hFFFF);
    enable = 1'b1;
    wait_cnt(16'd2, 400, ok);
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL t4_frames cnt=%0d want 2", cnt_m); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (log_b[(b0 + i) % 256] !== e[i]) begin
        bad++; $display("FAIL t4_byte%0d got=%h want=%h", i, log_b[(b0 + i) % 256], e[i]);
      end
    end
    total++;
    if (nrd - r0 !== 2) begin bad++; $display("FAIL t4_pops got=%0d want 2", nrd - r0); end
    total++;
    if (viol - v0 !== 0) begin bad++; $display("FAIL t4_send_while_active got=%0d want 0", viol - v0); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] e [5] = '{8'h49, 8'h0B, 8'hAD, 8'hBE, 8'hEF};
    int b0, b1; bit ok;
    sel = 0;
    @(negedge clk);
    b0 = nlog;
    push(64'hCAFEF00D);
    enable = 1'b1;
    wait_nlog(b0 + 3, 300, ok);
    total++;
    if (!ok || log_b[(b0 + 2) % 256] !== 8'hFE) begin
      bad++; $display("FAIL t5_pre_reset ok=%b byte=%h want 1 fe", ok, log_b[(b0 + 2) % 256]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({send_m, rd_m, busy_m, byte_m, cnt_m} !== 27'd0) begin
      bad++; $display("FAIL t5_reset_outs got=%h want=0", {send_m, rd_m, busy_m, byte_m, cnt_m});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    b1 = nlog;
    push(64'h0BADBEEF);
    wait_cnt(16'd1, 300, ok);
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (!ok || nlog - b1 !== 5) begin
      bad++; $display("FAIL t5_fresh_frame cnt=%0d sent=%0d want 1 5", cnt_m, nlog - b1);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (log_b[(b1 + i) % 256] !== e[i]) begin
        bad++; $display("FAIL t5_byte%0d got=%h want=%h", i, log_b[(b1 + i) % 256], e[i]);
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] e [5] = '{8'h49, 8'h01, 8'h02, 8'h03, 8'h04};
    int b0, r0; bit ok, started;
    logic [15:0] c0;
    sel = 0;
    @(negedge clk);
    b0 = nlog; r0 = nrd; c0 = cnt_m;
    enable = 1'b0;
    push(64'h01020304);
    repeat (1000) @(posedge clk);
    #1;
    total++;
    if (nlog - b0 !== 0 || busy_m !== 1'b0 || nrd - r0 !== 0) begin
      bad++; $display("FAIL t6_disabled sent=%0d busy=%b pops=%0d want 0 0 0", nlog - b0, busy_m, nrd - r0);
    end
    @(negedge clk);
    enable = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy_m) begin started = 1'b1; break; end
    end
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (!started) begin bad++; $display("FAIL t6_start busy=%b want 1", busy_m); end
    wait_cnt(c0 + 16'd1, 300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t6_complete cnt=%0d want %0d", cnt_m, c0 + 16'd1); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (log_b[(b0 + i) % 256] !== e[i]) begin
        bad++; $display("FAIL t6_byte%0d got=%h want=%h", i, log_b[(b0 + i) % 256], e[i]);
      end
    end
    total++;
    if (rd_bad !== 0) begin bad++; $display("FAIL pop_while_empty got=%0d want 0", rd_bad); end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    sel    = 0;
    test_reset();
    test_msb_first();
    test_lsb_checksum();
    test_fifo_stall();
    test_back_to_back();
    test_mid_reset();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
